// File: rtl/reg_arb_pkg.sv
// Shared types and defaults for the register_bank write-port arbiter.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_REQ0 = 2'b01;
  localparam logic [1:0] OWNER_REQ1 = 2'b10;

  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned SEL_W_DEF     = 3;
  localparam int unsigned MAX_BURST_DEF = 4;
  localparam int unsigned CNT_W         = 4;

endpackage

// File: rtl/reg_arb_burst_ctr.sv
// Saturating burst-length counter; o_at_max flags that the owner has
// used its full locked allowance.
module reg_arb_burst_ctr
  import reg_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_max;

  assign w_at_max = (r_cnt == CNT_W'(MAX_BURST));
  assign o_at_max = w_at_max;

  // Count locked grants, holding at MAX_BURST instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_at_max) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/register_write_arbiter.sv
// Two-requester arbiter for the register_bank write port with round-robin
// ties, optional burst lock with forced release, and a registered output stage.
// Optional: REG_ARB_FIXED_PRIORITY_EN makes IDLE ties always go to req0.
module register_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned SEL_W     = SEL_W_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_lock,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_lock,
  input  logic [SEL_W-1:0]  req1_sel,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              bank_write_en,
  output logic [SEL_W-1:0]  bank_rx_selector,
  output logic [DATA_W-1:0] bank_data,
  output logic [1:0]        owner
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              r_rr_last;    // 0: req0 granted last, 1: req1
  logic              w_rr_nxt;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_force_rel;
  logic              w_at_max;
  logic              w_cnt_inc;
  logic              w_cnt_clr;
  logic              r_wen;
  logic [SEL_W-1:0]  r_sel;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_owner;

  reg_arb_burst_ctr #(
    .MAX_BURST (MAX_BURST)
  ) u_burst_ctr (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_inc    (w_cnt_inc),
    .i_clr    (w_cnt_clr),
    .o_at_max (w_at_max)
  );

  // State register; req0 wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_rr_last <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_last <= w_rr_nxt;
    end
  end

  // Grant decision: at most one grant per cycle, none while in reset.
  always_comb begin
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    w_force_rel = 1'b0;
    if (!reset) begin
      case (r_state)
        IDLE: begin
          if (req0_valid && req1_valid) begin
`ifdef REG_ARB_FIXED_PRIORITY_EN
            w_grant0 = 1'b1;
`else
            if (r_rr_last) w_grant0 = 1'b1;
            else           w_grant1 = 1'b1;
`endif
          end else begin
            w_grant0 = req0_valid;
            w_grant1 = req1_valid;
          end
        end
        OWN0: begin
          if (req0_valid) begin
            if (w_at_max && req1_valid) w_force_rel = 1'b1;
            else                        w_grant0    = 1'b1;
          end
        end
        OWN1: begin
          if (req1_valid) begin
            if (w_at_max && req0_valid) w_force_rel = 1'b1;
            else                        w_grant1    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  // Next state, round-robin pointer and burst counter control.
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_last;
    w_cnt_inc   = 1'b0;
    w_cnt_clr   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant0) begin
          w_rr_nxt = 1'b0;
          if (req0_lock) begin
            w_state_nxt = OWN0;
            w_cnt_inc   = 1'b1;
          end
        end else if (w_grant1) begin
          w_rr_nxt = 1'b1;
          if (req1_lock) begin
            w_state_nxt = OWN1;
            w_cnt_inc   = 1'b1;
          end
        end
      end
      OWN0: begin
        if (w_grant0) begin
          w_rr_nxt = 1'b0;
          if (req0_lock) begin
            w_cnt_inc = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_cnt_clr   = 1'b1;
          end
        end else begin
          // Valid dropped or forced release; pointer stays on req0 so req1 wins next.
          w_state_nxt = IDLE;
          w_cnt_clr   = 1'b1;
          if (w_force_rel) w_rr_nxt = 1'b0;
        end
      end
      OWN1: begin
        if (w_grant1) begin
          w_rr_nxt = 1'b1;
          if (req1_lock) begin
            w_cnt_inc = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_cnt_clr   = 1'b1;
          end
        end else begin
          w_state_nxt = IDLE;
          w_cnt_clr   = 1'b1;
          if (w_force_rel) w_rr_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_clr   = 1'b1;
      end
    endcase
  end

  // Output stage: register the accepted write; selector/data hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wen   <= 1'b0;
      r_sel   <= '0;
      r_data  <= '0;
      r_owner <= OWNER_NONE;
    end else begin
      r_wen <= w_grant0 | w_grant1;
      if (w_grant0) begin
        r_sel   <= req0_sel;
        r_data  <= req0_data;
        r_owner <= OWNER_REQ0;
      end else if (w_grant1) begin
        r_sel   <= req1_sel;
        r_data  <= req1_data;
        r_owner <= OWNER_REQ1;
      end else begin
        r_owner <= OWNER_NONE;
      end
    end
  end

  assign bank_write_en    = r_wen;
  assign bank_rx_selector = r_sel;
  assign bank_data        = r_data;
  assign owner            = r_owner;

endmodule

// File: tb/tb_register_write_arbiter.sv
// Directed bench for register_write_arbiter with a small register_bank model.
module tb_register_write_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req0_lock = 1'b0;
  logic [2:0] req0_sel = '0;
  logic [7:0] req0_data = '0;
  logic       req0_ready;
  logic       req1_valid = 1'b0, req1_lock = 1'b0;
  logic [2:0] req1_sel = '0;
  logic [7:0] req1_data = '0;
  logic       req1_ready;
  logic       bank_write_en;
  logic [2:0] bank_rx_selector;
  logic [7:0] bank_data;
  logic [1:0] owner;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [8] = '{default: 8'h00};

  always #5 clk = ~clk;

  // register_bank stand-in: writes one edge after the output stage loads.
  always @(posedge clk) if (bank_write_en) mem[bank_rx_selector] <= bank_data;

  register_write_arbiter #(
    .DATA_W    (8),
    .SEL_W     (3),
    .MAX_BURST (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req0_valid       (req0_valid),
    .req0_lock        (req0_lock),
    .req0_sel         (req0_sel),
    .req0_data        (req0_data),
    .req0_ready       (req0_ready),
    .req1_valid       (req1_valid),
    .req1_lock        (req1_lock),
    .req1_sel         (req1_sel),
    .req1_data        (req1_data),
    .req1_ready       (req1_ready),
    .bank_write_en    (bank_write_en),
    .bank_rx_selector (bank_rx_selector),
    .bank_data        (bank_data),
    .owner            (owner)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic l, input logic [2:0] s, input logic [7:0] d);
    req0_valid = v; req0_lock = l; req0_sel = s; req0_data = d;
  endtask

  task automatic drive1(input logic v, input logic l, input logic [2:0] s, input logic [7:0] d);
    req1_valid = v; req1_lock = l; req1_sel = s; req1_data = d;
  endtask

  task automatic idle_all;
    req0_valid = 1'b0; req0_lock = 1'b0;
    req1_valid = 1'b0; req1_lock = 1'b0;
  endtask

  task automatic do_reset;
    idle_all;
    reset = 1'b1;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    idle_all;
    reset = 1'b1;
    tick;
    tick;
    total++; if (bank_write_en !== 1'b0) begin bad++; $display("FAIL reset_wen got=%0b want=0", bank_write_en); end
    total++; if (bank_rx_selector !== 3'd0) begin bad++; $display("FAIL reset_sel got=%0d want=0", bank_rx_selector); end
    total++; if (bank_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%0h want=00", bank_data); end
    total++; if (owner !== 2'b00) begin bad++; $display("FAIL reset_owner got=%b want=00", owner); end
    total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b%b want=00", req0_ready, req1_ready); end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_single_write;
    drive0(1'b1, 1'b0, 3'd4, 8'hAA);
    #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL single_rdy0 got=%0b want=1", req0_ready); end
    total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL single_rdy1 got=%0b want=0", req1_ready); end
    tick;
    total++; if (bank_write_en !== 1'b1) begin bad++; $display("FAIL single_wen got=%0b want=1", bank_write_en); end
    total++; if (bank_rx_selector !== 3'd4) begin bad++; $display("FAIL single_sel got=%0d want=4", bank_rx_selector); end
    total++; if (bank_data !== 8'hAA) begin bad++; $display("FAIL single_data got=%0h want=aa", bank_data); end
    total++; if (owner !== 2'b01) begin bad++; $display("FAIL single_owner got=%b want=01", owner); end
    idle_all;
    tick;
    total++; if (bank_write_en !== 1'b0) begin bad++; $display("FAIL single_wen_off got=%0b want=0", bank_write_en); end
    total++; if (bank_rx_selector !== 3'd4 || bank_data !== 8'hAA) begin bad++; $display("FAIL single_hold got=%0d/%0h want=4/aa", bank_rx_selector, bank_data); end
    total++; if (owner !== 2'b00) begin bad++; $display("FAIL single_owner_off got=%b want=00", owner); end
    total++; if (mem[4] !== 8'hAA) begin bad++; $display("FAIL single_bank_r4 got=%0h want=aa", mem[4]); end
  endtask

  task automatic test_tie_after_reset;
    do_reset;
    drive0(1'b1, 1'b0, 3'd1, 8'h11);
    drive1(1'b1, 1'b0, 3'd2, 8'h22);
    #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL tie_first got=%b%b want=10", req0_ready, req1_ready); end
    tick;
    total++; if (bank_rx_selector !== 3'd1 || bank_data !== 8'h11 || owner !== 2'b01) begin bad++; $display("FAIL tie_out1 got=%0d/%0h/%b want=1/11/01", bank_rx_selector, bank_data, owner); end
    drive0(1'b1, 1'b0, 3'd3, 8'h33);
    #1;
    total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin bad++; $display("FAIL tie_second got=%b%b want=01", req0_ready, req1_ready); end
    tick;
    total++; if (bank_write_en !== 1'b1 || bank_rx_selector !== 3'd2 || bank_data !== 8'h22 || owner !== 2'b10) begin bad++; $display("FAIL tie_out2 got=%0b/%0d/%0h/%b want=1/2/22/10", bank_write_en, bank_rx_selector, bank_data, owner); end
    idle_all;
    tick;
    tick;
    total++; if (mem[1] !== 8'h11 || mem[2] !== 8'h22) begin bad++; $display("FAIL tie_bank got=%0h/%0h want=11/22", mem[1], mem[2]); end
  endtask

  task automatic test_burst_release;
    logic [7:0] d;
    logic       e0, e1;
    logic [1:0] eo;
    // Prime round-robin so req1 wins the upcoming tie.
    drive0(1'b1, 1'b0, 3'd0, 8'h50);
    tick;
    idle_all;
    tick;
    drive0(1'b1, 1'b0, 3'd0, 8'h55);
    drive1(1'b1, 1'b1, 3'd6, 8'h60);
    for (int unsigned c = 0; c < 6; c++) begin
      #1;
      e1 = (c < 4);
      e0 = (c == 5);
      total++; if (req0_ready !== e0 || req1_ready !== e1) begin bad++; $display("FAIL burst_ready c=%0d got=%b%b want=%b%b", c, req0_ready, req1_ready, e0, e1); end
      tick;
      eo = (c < 4) ? 2'b10 : ((c == 4) ? 2'b00 : 2'b01);
      total++; if (owner !== eo) begin bad++; $display("FAIL burst_owner c=%0d got=%b want=%b", c, owner, eo); end
      if (c < 4) begin
        d = 8'h60 + 8'(c);
        total++; if (bank_data !== d) begin bad++; $display("FAIL burst_data c=%0d got=%0h want=%0h", c, bank_data, d); end
        req1_data = 8'h61 + 8'(c);
      end
      if (c == 4) begin
        total++; if (bank_write_en !== 1'b0) begin bad++; $display("FAIL burst_gap_wen got=%0b want=0", bank_write_en); end
      end
    end
    idle_all;
    tick;
    total++; if (mem[6] !== 8'h63 || mem[0] !== 8'h55) begin bad++; $display("FAIL burst_bank got=%0h/%0h want=63/55", mem[6], mem[0]); end
  endtask

  task automatic test_same_dest;
    drive0(1'b1, 1'b0, 3'd5, 8'h0F);
    drive1(1'b1, 1'b0, 3'd5, 8'hF0);
    #1;
    total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin bad++; $display("FAIL same_first got=%b%b want=01", req0_ready, req1_ready); end
    tick;
    total++; if (bank_data !== 8'hF0 || owner !== 2'b10) begin bad++; $display("FAIL same_out1 got=%0h/%b want=f0/10", bank_data, owner); end
    req1_valid = 1'b0;
    #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL same_second got=%0b want=1", req0_ready); end
    tick;
    total++; if (bank_data !== 8'h0F || owner !== 2'b01) begin bad++; $display("FAIL same_out2 got=%0h/%b want=0f/01", bank_data, owner); end
    idle_all;
    tick;
    total++; if (mem[5] !== 8'h0F) begin bad++; $display("FAIL same_bank_r5 got=%0h want=0f", mem[5]); end
  endtask

  task automatic test_saturate;
    logic [7:0] d;
    for (int unsigned c = 0; c < 6; c++) begin
      d = 8'h30 + 8'(c);
      drive0(1'b1, 1'b1, 3'd3, d);
      #1;
      total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL sat_ready c=%0d got=%0b want=1", c, req0_ready); end
      tick;
      total++; if (bank_data !== d) begin bad++; $display("FAIL sat_data c=%0d got=%0h want=%0h", c, bank_data, d); end
    end
    drive0(1'b1, 1'b1, 3'd3, 8'h36);
    drive1(1'b1, 1'b0, 3'd4, 8'h44);
    #1;
    total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++; $display("FAIL sat_release got=%b%b want=00", req0_ready, req1_ready); end
    tick;
    total++; if (bank_write_en !== 1'b0 || owner !== 2'b00) begin bad++; $display("FAIL sat_gap got=%0b/%b want=0/00", bank_write_en, owner); end
    #1;
    total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin bad++; $display("FAIL sat_handover got=%b%b want=01", req0_ready, req1_ready); end
    tick;
    total++; if (owner !== 2'b10 || bank_data !== 8'h44) begin bad++; $display("FAIL sat_out got=%b/%0h want=10/44", owner, bank_data); end
    idle_all;
    tick;
  endtask

  task automatic test_reset_mid_burst;
    drive0(1'b1, 1'b1, 3'd7, 8'h71);
    tick;
    drive0(1'b1, 1'b1, 3'd7, 8'h72);
    tick;
    total++; if (owner !== 2'b01 || bank_data !== 8'h72) begin bad++; $display("FAIL rst_pre got=%b/%0h want=01/72", owner, bank_data); end
    drive0(1'b1, 1'b1, 3'd7, 8'h73);
    reset = 1'b1;
    tick;
    total++; if (owner !== 2'b00 || bank_write_en !== 1'b0) begin bad++; $display("FAIL rst_cancel got=%b/%0b want=00/0", owner, bank_write_en); end
    reset = 1'b0;
    drive0(1'b1, 1'b0, 3'd1, 8'hA1);
    drive1(1'b1, 1'b0, 3'd2, 8'hB2);
    #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL rst_tie got=%b%b want=10", req0_ready, req1_ready); end
    tick;
    total++; if (owner !== 2'b01 || bank_data !== 8'hA1) begin bad++; $display("FAIL rst_out1 got=%b/%0h want=01/a1", owner, bank_data); end
    req0_valid = 1'b0;
    #1;
    total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL rst_second got=%0b want=1", req1_ready); end
    tick;
    total++; if (owner !== 2'b10 || bank_data !== 8'hB2) begin bad++; $display("FAIL rst_out2 got=%b/%0h want=10/b2", owner, bank_data); end
    idle_all;
    tick;
  endtask

  task automatic test_both_unlocked;
    logic e1;
    drive0(1'b1, 1'b0, 3'd0, 8'hC0);
    drive1(1'b1, 1'b0, 3'd1, 8'hD0);
    for (int unsigned c = 0; c < 4; c++) begin
      #1;
`ifdef REG_ARB_FIXED_PRIORITY_EN
      e1 = 1'b0;
`else
      e1 = c[0];
`endif
      total++; if (req0_ready !== !e1 || req1_ready !== e1) begin bad++; $display("FAIL both_ready c=%0d got=%b%b want=%b%b", c, req0_ready, req1_ready, !e1, e1); end
      tick;
    end
    req0_valid = 1'b0;
    #1;
    total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL both_req1_after got=%0b want=1", req1_ready); end
    tick;
    idle_all;
    tick;
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_tie_after_reset;
    test_burst_release;
    test_same_dest;
    test_saturate;
    test_reset_mid_burst;
    test_both_unlocked;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_write_arbiter.md
Name: register_write_arbiter

Overview:
- Shares the single write/rx port of the 8x8 register_bank between two requesters (req0 = ALU writeback, req1 = load unit).
- Per-requester valid/ready handshake; round-robin arbitration; optional burst lock so one requester keeps the port for consecutive writes.
- Drives register_bank write_en, in_rx_selector and in_data from a registered output stage.

Parameters:
- DATA_W, 8, data width; must match register_bank.
- SEL_W, 3, register selector width (8 registers).
- MAX_BURST, 4, maximum consecutive locked grants before forced release when the other requester is waiting; range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has a write pending
- req0_lock  in  1  requester 0 asks to keep ownership after this grant
- req0_sel  in  SEL_W  destination register
- req0_data  in  DATA_W  write data
- req0_ready  out  1  requester 0 write accepted this cycle
- req1_valid, req1_lock, req1_sel, req1_data, req1_ready  same as req0
- bank_write_en  out  1  to register_bank write_en
- bank_rx_selector  out  SEL_W  to register_bank in_rx_selector
- bank_data  out  DATA_W  to register_bank in_data
- owner  out  2  debug: 00 none, 01 req0, 10 req1

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on reset.
- Reset: state IDLE, rr_last = 1 (req0 wins the first tie), burst_cnt = 0, bank_write_en = 0, bank_rx_selector = 0, bank_data = 0, req*_ready = 0, owner = 00.
- Handshake:
  - A transfer occurs in cycle N when reqX_valid && reqX_ready at the rising edge.
  - reqX_ready is combinational from state and valids.
  - Requester holds sel/data/lock stable while valid && !ready.
  - Only one ready is high per cycle.
- Latency: a transfer in cycle N registers sel/data into bank_* with bank_write_en = 1 on edge N. register_bank writes at edge N+1. Throughput is one write per cycle.
- If no transfer occurs in a cycle, bank_write_en = 0 next cycle and bank_rx_selector/bank_data hold their last values.
- State machine: IDLE, OWN0, OWN1.
  - IDLE:
    - Exactly one valid: grant it.
    - Both valid: grant the requester other than rr_last.
    - Granted with lock = 1: go to OWNx with burst_cnt = 1.
    - Granted with lock = 0: stay IDLE.
    - rr_last is updated to the granted id.
  - OWNx:
    - Only requester x may be granted; the other's ready = 0.
    - Transfer with lock = 1: burst_cnt++.
    - Transfer with lock = 0: return to IDLE, burst_cnt = 0.
    - reqX_valid = 0 in OWNx: return to IDLE; no grant that cycle.
    - Forced release: burst_cnt == MAX_BURST and the other valid = 1. No grant to x that cycle; go to IDLE, burst_cnt = 0, rr_last = x, so the other wins next cycle.
    - burst_cnt saturates at MAX_BURST when the other requester is idle.
- Same-destination collisions: both valid to the same register are serialized in grant order. The later write wins in the bank. No merging.
- Reset mid-burst: ownership is dropped immediately; a write registered in the output stage is cancelled (bank_write_en = 0 after the reset edge).
- Arithmetic: burst_cnt is 4 bits, compared unsigned; no wrap because of saturation.

Optional Feature:
- Macro: REG_ARB_FIXED_PRIORITY_EN
- Defined: IDLE ties always go to req0; rr_last is ignored; burst lock and forced release are unchanged.
- Undefined: round-robin as specified above.

Decomposition:
- Package reg_arb_pkg:
  - State encodings IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2.
  - Owner codes.
  - DATA_W/SEL_W defaults.
- One sub-module, reg_arb_burst_ctr: 4-bit saturating counter with inc/clear inputs and an at_max output against MAX_BURST.
- Arbitration and the output stage live in the top module.

Test Plan:
- Reset, then req0_valid, sel = 3'b100, data = 8'hAA, lock = 0 -> req0_ready = 1 in the same cycle; bank_write_en = 1, selector = 4, data = AA after the next edge; register_bank out_rx_data = 8'hAA one edge later.
- Both valid in IDLE after reset (req0: r1 = 8'h11; req1: r2 = 8'h22), held across cycles -> grant order req0, req1; bank writes r1 = 11 then r2 = 22 on consecutive cycles.
- req1 lock = 1 for 6 writes while req0 continuously valid, MAX_BURST = 4 -> req1 granted 4 times, one gap cycle with no grant, req0 granted next; owner goes 10, 10, 10, 10, 00, then req0.
- Both write r5 in the same cycle (req0: 8'h0F, req1: 8'hF0) with rr_last = 0 -> req1 first, then req0; final r5 = 8'h0F.
- Reset asserted in OWN0 after 2 locked writes -> next cycle owner = 00, bank_write_en = 0, req1 ties are granted per reset rr_last (req0 first).
- Build with REG_ARB_FIXED_PRIORITY_EN, both valid and unlocked for 4 cycles -> req0 granted every cycle; req1_ready stays 0 until req0_valid drops.
